// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

endpackage

// File: rtl/arb_rsp_tracker.sv
// Owner tag for the single in-flight memory access and steering of the
// returning read data to the requester that was granted the previous cycle.
module arb_rsp_tracker
  import arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_gnt,
  input  logic          dm_gnt,
  input  logic          dm_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata
);

  owner_t owner_reg, owner_next;
  logic   store_reg, store_next;
  logic   if_sel, dm_sel, dm_load_sel;

  always_comb begin
    owner_next = OWN_NONE;
    store_next = 1'b0;
    if (if_gnt) begin
      owner_next = OWN_IF;
    end else if (dm_gnt) begin
      owner_next = OWN_DM;
      store_next = dm_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= OWN_NONE;
      store_reg <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      store_reg <= store_next;
    end
  end

  // Gating with rst drops a response that was in flight when reset arrived.
  assign if_sel      = (owner_reg == OWN_IF) & ~rst;
  assign dm_sel      = (owner_reg == OWN_DM) & ~rst;
  assign dm_load_sel = dm_sel & ~store_reg;

  assign if_valid = if_sel;
  assign dm_valid = dm_sel;

  for (genvar gi = 0; gi < DW; gi++) begin : g_rdata
    assign if_rdata[gi] = mem_rdata[gi] & if_sel;
    assign dm_rdata[gi] = mem_rdata[gi] & dm_load_sel;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between fetch and load/store, data first
// with a bounded streak. Optional perf counters behind ARB_PERF_CNT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_dm_cnt,
`endif
  output logic          pc_stall
);

  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIM);

  logic [STREAK_W-1:0] streak_reg, streak_next;

  always_comb begin
    dm_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!rst) begin
      if (dm_req && (!if_req || streak_reg < LIM)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Counts data grants taken while fetch is waiting; saturates rather than wraps.
  always_comb begin
    streak_next = streak_reg;
    if (if_gnt || !if_req) begin
      streak_next = '0;
    end else if (dm_gnt && streak_reg != STREAK_MAX) begin
      streak_next = streak_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = dm_gnt ? dm_wdata : '0;
  assign pc_stall  = if_req & ~if_gnt & ~rst;

  arb_rsp_tracker #(
    .DW(DW)
  ) u_rsp_tracker (
    .clk      (clk),
    .rst      (rst),
    .if_gnt   (if_gnt),
    .dm_gnt   (dm_gnt),
    .dm_we    (dm_we),
    .mem_rdata(mem_rdata),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .dm_valid (dm_valid),
    .dm_rdata (dm_rdata)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, dm_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      dm_cnt_reg    <= '0;
    end else begin
      if (pc_stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (dm_gnt)   dm_cnt_reg    <= dm_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = rst ? '0 : stall_cnt_reg;
  assign perf_dm_cnt    = rst ? '0 : dm_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// request stream checked against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_valid, dm_gnt, dm_valid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          mem_en, mem_we, pc_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt, perf_dm_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_dm_cnt(perf_dm_cnt),
`endif
    .pc_stall(pc_stall)
  );

  // Memory attached to the port (1-cycle read latency)
  logic [DW-1:0] mem     [0:255];
  logic [DW-1:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // Reference model state: 0 = none, 1 = fetch, 2 = data
  int            m_streak;
  int            p_owner;
  logic [DW-1:0] p_data;
  int            hist[$];
  logic          obs_if_valid, obs_dm_valid;
  logic [DW-1:0] obs_dm_rdata;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_cyc    = 0;

  task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd);
    int            g;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_if_rdata, e_dm_rdata;
    @(negedge clk);
    rst = 1'b0; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    #1;
    g          = (dr && (!ir || m_streak < LIM)) ? 2 : (ir ? 1 : 0);
    e_addr     = (g == 2) ? da : ((g == 1) ? ia : '0);
    e_wdata    = (g == 2) ? dd : '0;
    e_if_rdata = (p_owner == 1) ? p_data : '0;
    e_dm_rdata = (p_owner == 2) ? p_data : '0;
    n_cyc++;
    $display("cyc %0d: if_req=%0b dm_req=%0b we=%0b grant=%0d if_valid=%0b dm_valid=%0b streak=%0d",
             n_cyc, ir, dr, dw, g, if_valid, dm_valid, m_streak);

    n_checks++;
    if ({if_gnt, dm_gnt} !== {g == 1, g == 2}) begin
      n_fail++;
      $display("FAIL grant cyc %0d: got if_gnt=%0b dm_gnt=%0b, want grant=%0d", n_cyc, if_gnt, dm_gnt, g);
    end
    n_checks++;
    if (pc_stall !== (ir && g != 1)) begin
      n_fail++;
      $display("FAIL pc_stall cyc %0d: got %0b want %0b", n_cyc, pc_stall, ir && g != 1);
    end
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {g != 0, g == 2 && dw, e_addr, e_wdata}) begin
      n_fail++;
      $display("FAIL mem_port cyc %0d: got en=%0b we=%0b addr=%h wdata=%h, want en=%0b we=%0b addr=%h wdata=%h",
               n_cyc, mem_en, mem_we, mem_addr, mem_wdata, g != 0, g == 2 && dw, e_addr, e_wdata);
    end
    n_checks++;
    if ({if_valid, if_rdata} !== {p_owner == 1, e_if_rdata}) begin
      n_fail++;
      $display("FAIL if_rsp cyc %0d: got valid=%0b rdata=%h, want valid=%0b rdata=%h",
               n_cyc, if_valid, if_rdata, p_owner == 1, e_if_rdata);
    end
    n_checks++;
    if ({dm_valid, dm_rdata} !== {p_owner == 2, e_dm_rdata}) begin
      n_fail++;
      $display("FAIL dm_rsp cyc %0d: got valid=%0b rdata=%h, want valid=%0b rdata=%h",
               n_cyc, dm_valid, dm_rdata, p_owner == 2, e_dm_rdata);
    end
    obs_if_valid = if_valid;
    obs_dm_valid = dm_valid;
    obs_dm_rdata = dm_rdata;

    p_owner = g;
    p_data  = '0;
    if (g == 1) begin
      p_data = ref_mem[ia[9:2]];
    end else if (g == 2) begin
      if (dw) ref_mem[da[9:2]] = dd;
      else    p_data = ref_mem[da[9:2]];
    end
    if (g == 1 || !ir)               m_streak = 0;
    else if (g == 2 && m_streak < 15) m_streak = m_streak + 1;
    hist.push_back(g);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ir, input logic dr);
    @(negedge clk);
    rst = 1'b1; if_req = ir; dm_req = dr; dm_we = 1'b0;
    if_addr = 32'h0000_0100; dm_addr = 32'h0000_0200; dm_wdata = 32'h1234_5678;
    #1;
    n_checks++;
    if ({if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
         mem_en, mem_we, mem_addr, mem_wdata, pc_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got if_gnt=%0b if_valid=%0b dm_gnt=%0b dm_valid=%0b mem_en=%0b pc_stall=%0b, want all 0",
               if_gnt, if_valid, dm_gnt, dm_valid, mem_en, pc_stall);
    end
`ifdef ARB_PERF_CNT_EN
    n_checks++;
    if ({perf_stall_cnt, perf_dm_cnt} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_perf: got stall=%0d dm=%0d want 0 0", perf_stall_cnt, perf_dm_cnt);
    end
`endif
    $display("reset cycle: if_req=%0b dm_req=%0b", ir, dr);
    p_owner  = 0;
    m_streak = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    idle();
  endtask

  task automatic test_fetch_seq();
    int b;
    b = hist.size();
    step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
    step(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
    idle();
    n_checks++;
    if (hist[b] != 1 || hist[b+1] != 1 || hist[b+2] != 1 || !obs_if_valid) begin
      n_fail++;
      $display("FAIL fetch_seq: got grants %0d %0d %0d last if_valid=%0b, want 1 1 1 and 1",
               hist[b], hist[b+1], hist[b+2], obs_if_valid);
    end
  endtask

  task automatic test_data_priority();
    int            b;
    logic [DW-1:0] want;
    b    = hist.size();
    want = ref_mem[16];
    step(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, '0);
    step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (hist[b] != 2 || hist[b+1] != 1 || !obs_dm_valid || obs_dm_rdata !== want) begin
      n_fail++;
      $display("FAIL data_priority: got grants %0d %0d dm_valid=%0b dm_rdata=%h, want 2 1 1 %h",
               hist[b], hist[b+1], obs_dm_valid, obs_dm_rdata, want);
    end
    idle();
  endtask

  task automatic test_starvation();
    int b;
    int exp_g[6] = '{2, 2, 2, 1, 2, 2};
`ifdef ARB_PERF_CNT_EN
    logic [31:0] s0, d0;
`endif
    idle();
`ifdef ARB_PERF_CNT_EN
    s0 = perf_stall_cnt;
    d0 = perf_dm_cnt;
`endif
    b = hist.size();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 32'h300 + 32'(4 * i), '0);
    end
`ifdef ARB_PERF_CNT_EN
    n_checks++;
    if (perf_dm_cnt - d0 !== 32'd5 || perf_stall_cnt - s0 !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_cnt: got dm=%0d stall=%0d want 5 5", perf_dm_cnt - d0, perf_stall_cnt - s0);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (hist[b+i] != exp_g[i]) begin
        n_fail++;
        $display("FAIL starve_seq[%0d]: got grant %0d want %0d", i, hist[b+i], exp_g[i]);
      end
    end
    idle();
  endtask

  task automatic test_store_load();
    logic ack_v;
    logic [DW-1:0] ack_d;
    step(1'b0, '0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step(1'b0, '0, 1'b1, 1'b0, 32'h10, '0);
    ack_v = obs_dm_valid;
    ack_d = obs_dm_rdata;
    idle();
    n_checks++;
    if (!ack_v || ack_d !== '0 || !obs_dm_valid || obs_dm_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_load: got ack=%0b/%h load=%0b/%h, want 1/00000000 1/deadbeef",
               ack_v, ack_d, obs_dm_valid, obs_dm_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    step(1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
    do_reset(1'b1, 1'b0);
    b = hist.size();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h24, 1'b1, 1'b0, 32'h44, '0);
    n_checks++;
    if (hist[b] != 2 || hist[b+1] != 2 || hist[b+2] != 2 || hist[b+3] != 1) begin
      n_fail++;
      $display("FAIL reset_streak: got grants %0d %0d %0d %0d want 2 2 2 1",
               hist[b], hist[b+1], hist[b+2], hist[b+3]);
    end
    idle();
  endtask

  task automatic test_random();
    logic          h_if = 1'b0, h_dm = 1'b0, h_dw = 1'b0;
    logic [AW-1:0] h_ia = '0, h_da = '0;
    logic [DW-1:0] h_dd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!h_if) begin
        h_if = 1'($urandom_range(0, 1));
        h_ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!h_dm) begin
        h_dm = ($urandom_range(0, 3) != 0);
        h_dw = 1'($urandom_range(0, 1));
        h_da = 32'($urandom_range(0, 255)) << 2;
        h_dd = $urandom;
      end
      step(h_if, h_ia, h_dm, h_dw, h_da, h_dd);
      if (hist[$] == 1) h_if = 1'b0;
      if (hist[$] == 2) h_dm = 1'b0;
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    m_streak = 0; p_owner = 0; p_data = '0;
    test_reset();
    test_fetch_seq();
    test_data_priority();
    test_starvation();
    test_store_load();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
